// File: rtl/dmux4way_scheduler.sv
// rtl/dmux4way_scheduler.sv - FIFO-buffered round-robin feeder for a 16-bit 4-way demux
// Words are queued, then each is bound to one enabled channel and held until that channel accepts it.
module dmux4way_scheduler #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 chan_en,
   input  logic [3:0]                 chan_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [1:0]                 out_sel,
   output logic                       out_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d;
   logic [1:0]       ptr_q, ptr_d;

   logic             push, accept, load, grant_found;
   logic [1:0]       grant_sel, cand;

   // in_ready deliberately ignores a same-cycle pop, so a full FIFO never pushes
   assign in_ready = rst_n && (count_q < FULL);
   assign push     = in_valid && in_ready;
   assign accept   = (state_q == PRESENT) && chan_ready[out_sel_q];
   assign load     = ((state_q == IDLE) || accept) && (count_q != '0) && (chan_en != 4'b0000);

   // Round-robin search starting just after the last granted channel
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = ptr_q;
      cand        = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!grant_found && chan_en[cand]) begin
            grant_found = 1'b1;
            grant_sel   = cand;
         end
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      ptr_d      = ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (load) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         out_data_d = mem_q[rd_ptr_q];
         out_sel_d  = grant_sel;
         ptr_d      = grant_sel;
      end else if (accept) begin
         out_data_d = '0;
      end
      case ({push, load})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (load)        state_d = PRESENT;
      else if (accept) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_data_q <= '0;
         out_sel_q  <= '0;
         ptr_q      <= 2'd3;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
         ptr_q      <= ptr_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      out_valid = (state_q == PRESENT);
      out_data  = out_data_q;
      out_sel   = out_sel_q;
      count     = count_q;
   end

endmodule
